// File: rtl/d_victim_cache_ctrl.sv
// 8-way victim cache controller: one-cycle lookup of an L1 miss, swap-in of the
// L1 evicted line, and a stalled writeback path for dirty victims.
module d_victim_cache_ctrl #(
  parameter int TAG_W    = 20,
  parameter int LINE_W   = 128,
  parameter int INDEX_VC = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [INDEX_VC-1:0] req_index_i,
  input  logic [TAG_W-1:0]    req_tag_i,
  input  logic                evict_valid_i,
  input  logic [TAG_W-1:0]    evict_tag_i,
  input  logic [LINE_W-1:0]   evict_data_i,
  input  logic                evict_dirty_i,
  output logic                resp_valid_o,
  output logic                resp_hit_o,
  output logic [LINE_W-1:0]   resp_data_o,
  output logic                resp_dirty_o,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [TAG_W-1:0]    wb_tag_o,
  output logic [INDEX_VC-1:0] wb_index_o,
  output logic [LINE_W-1:0]   wb_data_o,
  output logic                plru_valid_o,
  output logic [INDEX_VC-1:0] plru_index_o,
  output logic [2:0]          plru_way_o,
  input  logic [2:0]          plru_victim_i
);

  localparam int DEPTH_VC = 1 << INDEX_VC;
  localparam int WAYS     = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WRITEBACK
  } state_e;

  state_e state_q;

  logic [WAYS-1:0]   valid_q    [DEPTH_VC];
  logic [WAYS-1:0]   dirty_q    [DEPTH_VC];
  logic [TAG_W-1:0]  tag_mem_q  [DEPTH_VC][WAYS];
  logic [LINE_W-1:0] data_mem_q [DEPTH_VC][WAYS];

  logic [INDEX_VC-1:0] idx_q;
  logic [TAG_W-1:0]    req_tag_q;
  logic                ev_valid_q;
  logic [TAG_W-1:0]    ev_tag_q;
  logic [LINE_W-1:0]   ev_data_q;
  logic                ev_dirty_q;
  logic [2:0]          tgt_q;

  logic            accept;
  logic            in_lookup;
  logic            in_wb;
  logic [WAYS-1:0] set_valid;
  logic [WAYS-1:0] set_dirty;
  logic [WAYS-1:0] hit_vec;
  logic            hit;
  logic [2:0]      hit_way;
  logic            any_free;
  logic [2:0]      free_way;
  logic [2:0]      tgt_way;
  logic            tgt_dirty;
  logic            wr_en;
  logic            clr_en;
  logic [2:0]      wr_way;
  logic            upd_en;

  assign accept    = req_valid_i & req_ready_o;
  assign in_lookup = !rst_i && (state_q == LOOKUP);
  assign in_wb     = !rst_i && (state_q == WRITEBACK);

  // Lookup decode on the captured set; lowest-numbered way wins both searches.
  always_comb begin
    set_valid = valid_q[idx_q];
    set_dirty = dirty_q[idx_q];
    hit_vec   = '0;
    hit_way   = '0;
    free_way  = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = set_valid[w] && (tag_mem_q[idx_q][w] == req_tag_q);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = 3'(w);
      if (!set_valid[w]) free_way = 3'(w);
    end
  end

  assign hit       = |hit_vec;
  assign any_free  = ~&set_valid;
  assign tgt_way   = any_free ? free_way : plru_victim_i;
  assign tgt_dirty = set_valid[tgt_way] & set_dirty[tgt_way];

  // Every storage update (insert or invalidate) is also the single pLRU touch.
  always_comb begin
    wr_en  = 1'b0;
    clr_en = 1'b0;
    wr_way = '0;
    if (in_lookup) begin
      if (hit) begin
        wr_en  = ev_valid_q;
        clr_en = !ev_valid_q;
        wr_way = hit_way;
      end else if (ev_valid_q && !tgt_dirty) begin
        wr_en  = 1'b1;
        wr_way = tgt_way;
      end
    end else if (in_wb && wb_ready_i) begin
      wr_en  = 1'b1;
      wr_way = tgt_q;
    end
  end

  assign upd_en = wr_en | clr_en;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ev_valid_q <= 1'b0;
      tgt_q      <= '0;
      for (int s = 0; s < DEPTH_VC; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      if (wr_en) begin
        valid_q[idx_q][wr_way] <= 1'b1;
        dirty_q[idx_q][wr_way] <= ev_dirty_q;
      end
      if (clr_en) begin
        valid_q[idx_q][wr_way] <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q      <= req_index_i;
            ev_valid_q <= evict_valid_i;
            state_q    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!hit && ev_valid_q) begin
            tgt_q <= tgt_way;
          end
          if (!hit && ev_valid_q && tgt_dirty) begin
            state_q <= WRITEBACK;
          end else begin
            state_q <= IDLE;
          end
        end
        WRITEBACK: begin
          if (wb_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag/data payload carries no reset; the valid bits qualify it.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_tag_q  <= req_tag_i;
      ev_tag_q   <= evict_tag_i;
      ev_data_q  <= evict_data_i;
      ev_dirty_q <= evict_dirty_i;
    end
    if (wr_en) begin
      tag_mem_q[idx_q][wr_way]  <= ev_tag_q;
      data_mem_q[idx_q][wr_way] <= ev_data_q;
    end
  end

  assign req_ready_o  = !rst_i && (state_q == IDLE);
  assign resp_valid_o = in_lookup;
  assign resp_hit_o   = in_lookup & hit;
  assign resp_data_o  = (in_lookup && hit) ? data_mem_q[idx_q][hit_way] : '0;
  assign resp_dirty_o = in_lookup & hit & set_dirty[hit_way];

  assign wb_valid_o = in_wb;
  assign wb_tag_o   = in_wb ? tag_mem_q[idx_q][tgt_q] : '0;
  assign wb_index_o = in_wb ? idx_q : '0;
  assign wb_data_o  = in_wb ? data_mem_q[idx_q][tgt_q] : '0;

  assign plru_valid_o = upd_en;
  assign plru_index_o = rst_i ? '0 : idx_q;
  assign plru_way_o   = upd_en ? wr_way : '0;

endmodule
